// File: rtl/core_pkg.sv
// Shared core types plus CSR addresses, mstatus bit positions and WARL masks for the trap controller.
// Only the mpp_warl helper depends on whether S-mode (CORE_SMODE_EN) is built; callers pass that in.
package core_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [4:0] {
        EX_INSTR_MISALIGNED  = 5'd0,
        EX_INSTR_FAULT       = 5'd1,
        EX_ILLEGAL_INSTR     = 5'd2,
        EX_BREAKPOINT        = 5'd3,
        EX_LOAD_MISALIGNED   = 5'd4,
        EX_LOAD_FAULT        = 5'd5,
        EX_STORE_MISALIGNED  = 5'd6,
        EX_STORE_FAULT       = 5'd7,
        EX_ECALL_U           = 5'd8,
        EX_ECALL_S           = 5'd9,
        EX_ECALL_M           = 5'd11,
        EX_INSTR_PAGE_FAULT  = 5'd12,
        EX_LOAD_PAGE_FAULT   = 5'd13,
        EX_STORE_PAGE_FAULT  = 5'd15
    } exception_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MEDELEG  = 12'h302;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_SSTATUS  = 12'h100;
    localparam logic [11:0] CSR_STVEC    = 12'h105;
    localparam logic [11:0] CSR_SSCRATCH = 12'h140;
    localparam logic [11:0] CSR_SEPC     = 12'h141;
    localparam logic [11:0] CSR_SCAUSE   = 12'h142;
    localparam logic [11:0] CSR_STVAL    = 12'h143;

    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;
    localparam logic [31:0] XTVEC_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] XEPC_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] MEDELEG_MASK = 32'hFFFF_F7FF;

    // Unsupported privilege encodings written to MPP leave the field unchanged.
    function automatic logic [1:0] mpp_warl(logic [1:0] old_mpp, logic [1:0] new_mpp,
                                            logic smode_en);
        if (new_mpp == 2'b10 || (!smode_en && new_mpp == 2'b01)) begin
            return old_mpp;
        end
        return new_mpp;
    endfunction

endpackage

// File: rtl/core_trap_ctrl_if.sv
// CSR access bus between the CSR unit (master) and the trap controller (slave).
interface core_trap_ctrl_if;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;

    modport master (output csr_addr, csr_we, csr_wdata, input csr_rdata, csr_hit);
    modport slave  (input csr_addr, csr_we, csr_wdata, output csr_rdata, csr_hit);
endinterface

// File: rtl/core_trap_deleg.sv
// Exception delegation decision: trap to S when not in M and the cause is delegated in medeleg.
module core_trap_deleg
    import core_pkg::*;
(
    input  priv_e       priv,
    input  logic [31:0] medeleg,
    input  exception_e  cause,
    output logic        to_smode
);
    logic [4:0] cause_idx;

    assign cause_idx = cause;
    assign to_smode  = (priv != PRIV_M) && medeleg[cause_idx];
endmodule

// File: rtl/core_trap_ctrl.sv
// Trap-state owner: privilege mode, mstatus trap fields, M/S trap CSRs and trap entry/return redirect.
// S-mode, delegation, medeleg and the S CSRs exist only when CORE_SMODE_EN is defined.
module core_trap_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    exception_valid,
    input  exception_e              exception_cause,
    input  logic [31:0]             exception_value,
    input  logic [31:0]             exception_pc,
    input  logic                    mret,
    input  logic                    sret,
    core_trap_ctrl_if.slave         csr,
    output priv_e                   priv,
    output logic                    trap_redirect,
    output logic [31:0]             trap_target
);

`ifdef CORE_SMODE_EN
    localparam logic SMODE = 1'b1;
`else
    localparam logic SMODE = 1'b0;
`endif

    priv_e       priv_q, priv_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [1:0]  mpp_q, mpp_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d, mscratch_q, mscratch_d;

    // S-side values shared by both builds; tied to zero when S-mode is absent.
    logic        sie_w, spie_w, spp_w, sret_en;
    logic [31:0] medeleg_w, stvec_w, sepc_w;

    logic        to_smode, csr_wr_en;
    logic [31:0] mstatus_rd;

`ifdef CORE_SMODE_EN
    logic        sie_q, sie_d, spie_q, spie_d, spp_q, spp_d;
    logic [31:0] medeleg_q, medeleg_d, stvec_q, stvec_d, sepc_q, sepc_d;
    logic [31:0] scause_q, scause_d, stval_q, stval_d, sscratch_q, sscratch_d;

    assign sie_w     = sie_q;
    assign spie_w    = spie_q;
    assign spp_w     = spp_q;
    assign sret_en   = sret;
    assign medeleg_w = medeleg_q;
    assign stvec_w   = stvec_q;
    assign sepc_w    = sepc_q;
`else
    assign sie_w     = 1'b0;
    assign spie_w    = 1'b0;
    assign spp_w     = 1'b0;
    assign sret_en   = 1'b0;
    assign medeleg_w = '0;
    assign stvec_w   = '0;
    assign sepc_w    = '0;
`endif

    core_trap_deleg u_deleg (
        .priv     (priv_q),
        .medeleg  (medeleg_w),
        .cause    (exception_cause),
        .to_smode (to_smode)
    );

    // Any trap event in the same cycle wins over a CSR write.
    assign csr_wr_en     = csr.csr_we && !(exception_valid || mret || sret);
    assign trap_redirect = !rst && (exception_valid || mret || sret_en);
    assign priv          = priv_q;

    always_comb begin
        trap_target = mepc_q;
        if (exception_valid) begin
            trap_target = to_smode ? stvec_w : mtvec_q;
        end else if (mret) begin
            trap_target = mepc_q;
        end else if (sret_en) begin
            trap_target = sepc_w;
        end
    end

    always_comb begin
        priv_d     = priv_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mpp_d      = mpp_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mscratch_d = mscratch_q;
`ifdef CORE_SMODE_EN
        sie_d      = sie_q;
        spie_d     = spie_q;
        spp_d      = spp_q;
        medeleg_d  = medeleg_q;
        stvec_d    = stvec_q;
        sepc_d     = sepc_q;
        scause_d   = scause_q;
        stval_d    = stval_q;
        sscratch_d = sscratch_q;
`endif
        if (exception_valid) begin
            if (to_smode) begin
`ifdef CORE_SMODE_EN
                sepc_d   = exception_pc & XEPC_MASK;
                scause_d = {27'b0, exception_cause};
                stval_d  = exception_value;
                spie_d   = sie_q;
                sie_d    = 1'b0;
                spp_d    = (priv_q == PRIV_S);
                priv_d   = PRIV_S;
`endif
            end else begin
                mepc_d   = exception_pc & XEPC_MASK;
                mcause_d = {27'b0, exception_cause};
                mtval_d  = exception_value;
                mpie_d   = mie_q;
                mie_d    = 1'b0;
                mpp_d    = priv_q;
                priv_d   = PRIV_M;
            end
        end else if (mret) begin
            priv_d = priv_e'(mpp_q);
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            mpp_d  = PRIV_U;
`ifdef CORE_SMODE_EN
        end else if (sret_en) begin
            priv_d = spp_q ? PRIV_S : PRIV_U;
            sie_d  = spie_q;
            spie_d = 1'b1;
            spp_d  = 1'b0;
`endif
        end else if (csr_wr_en) begin
            case (csr.csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = csr.csr_wdata[MSTATUS_MIE];
                    mpie_d = csr.csr_wdata[MSTATUS_MPIE];
                    mpp_d  = mpp_warl(mpp_q, csr.csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO], SMODE);
`ifdef CORE_SMODE_EN
                    sie_d  = csr.csr_wdata[MSTATUS_SIE];
                    spie_d = csr.csr_wdata[MSTATUS_SPIE];
                    spp_d  = csr.csr_wdata[MSTATUS_SPP];
`endif
                end
                CSR_MTVEC:    mtvec_d    = csr.csr_wdata & XTVEC_MASK;
                CSR_MEPC:     mepc_d     = csr.csr_wdata & XEPC_MASK;
                CSR_MCAUSE:   mcause_d   = csr.csr_wdata;
                CSR_MTVAL:    mtval_d    = csr.csr_wdata;
                CSR_MSCRATCH: mscratch_d = csr.csr_wdata;
`ifdef CORE_SMODE_EN
                CSR_SSTATUS: begin
                    sie_d  = csr.csr_wdata[MSTATUS_SIE];
                    spie_d = csr.csr_wdata[MSTATUS_SPIE];
                    spp_d  = csr.csr_wdata[MSTATUS_SPP];
                end
                CSR_MEDELEG:  medeleg_d  = csr.csr_wdata & MEDELEG_MASK;
                CSR_STVEC:    stvec_d    = csr.csr_wdata & XTVEC_MASK;
                CSR_SEPC:     sepc_d     = csr.csr_wdata & XEPC_MASK;
                CSR_SCAUSE:   scause_d   = csr.csr_wdata;
                CSR_STVAL:    stval_d    = csr.csr_wdata;
                CSR_SSCRATCH: sscratch_d = csr.csr_wdata;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            priv_q     <= PRIV_M;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mpp_q      <= 2'b00;
            mtvec_q    <= MTVEC_RESET & XTVEC_MASK;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mscratch_q <= '0;
        end else begin
            priv_q     <= priv_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mpp_q      <= mpp_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mscratch_q <= mscratch_d;
        end
    end

`ifdef CORE_SMODE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sie_q      <= 1'b0;
            spie_q     <= 1'b0;
            spp_q      <= 1'b0;
            medeleg_q  <= '0;
            stvec_q    <= '0;
            sepc_q     <= '0;
            scause_q   <= '0;
            stval_q    <= '0;
            sscratch_q <= '0;
        end else begin
            sie_q      <= sie_d;
            spie_q     <= spie_d;
            spp_q      <= spp_d;
            medeleg_q  <= medeleg_d;
            stvec_q    <= stvec_d;
            sepc_q     <= sepc_d;
            scause_q   <= scause_d;
            stval_q    <= stval_d;
            sscratch_q <= sscratch_d;
        end
    end
`endif

    always_comb begin
        mstatus_rd                                = '0;
        mstatus_rd[MSTATUS_SIE]                   = sie_w;
        mstatus_rd[MSTATUS_MIE]                   = mie_q;
        mstatus_rd[MSTATUS_SPIE]                  = spie_w;
        mstatus_rd[MSTATUS_MPIE]                  = mpie_q;
        mstatus_rd[MSTATUS_SPP]                   = spp_w;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
    end

    always_comb begin
        csr.csr_hit   = 1'b1;
        csr.csr_rdata = '0;
        case (csr.csr_addr)
            CSR_MSTATUS:  csr.csr_rdata = mstatus_rd;
            CSR_MTVEC:    csr.csr_rdata = mtvec_q;
            CSR_MEPC:     csr.csr_rdata = mepc_q;
            CSR_MCAUSE:   csr.csr_rdata = mcause_q;
            CSR_MTVAL:    csr.csr_rdata = mtval_q;
            CSR_MSCRATCH: csr.csr_rdata = mscratch_q;
`ifdef CORE_SMODE_EN
            CSR_SSTATUS:  csr.csr_rdata = mstatus_rd & SSTATUS_MASK;
            CSR_MEDELEG:  csr.csr_rdata = medeleg_q;
            CSR_STVEC:    csr.csr_rdata = stvec_q;
            CSR_SEPC:     csr.csr_rdata = sepc_q;
            CSR_SCAUSE:   csr.csr_rdata = scause_q;
            CSR_STVAL:    csr.csr_rdata = stval_q;
            CSR_SSCRATCH: csr.csr_rdata = sscratch_q;
`endif
            default:      csr.csr_hit   = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_core_trap_ctrl.sv
// Scoreboard bench for core_trap_ctrl: a CSR-array reference model predicts each cycle's outputs.
// Follows the build's CORE_SMODE_EN setting.
module tb_core_trap_ctrl;
    import core_pkg::*;

`ifdef CORE_SMODE_EN
    localparam bit SMODE = 1'b1;
`else
    localparam bit SMODE = 1'b0;
`endif
    localparam logic [31:0] MTVEC_RST = 32'h0000_0103;

    localparam logic [31:0] B_SIE  = 32'h0000_0002;
    localparam logic [31:0] B_MIE  = 32'h0000_0008;
    localparam logic [31:0] B_SPIE = 32'h0000_0020;
    localparam logic [31:0] B_MPIE = 32'h0000_0080;
    localparam logic [31:0] B_SPP  = 32'h0000_0100;
    localparam logic [31:0] S_VIEW = 32'h0000_0122;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exception_valid = 1'b0;
    exception_e  exception_cause = EX_INSTR_MISALIGNED;
    logic [31:0] exception_value = '0;
    logic [31:0] exception_pc = '0;
    logic        mret = 1'b0;
    logic        sret = 1'b0;
    priv_e       priv;
    logic        trap_redirect;
    logic [31:0] trap_target;

    core_trap_ctrl_if csr_bus ();

    always #5 clk = ~clk;

    core_trap_ctrl #(.MTVEC_RESET(MTVEC_RST)) dut (
        .clk             (clk),
        .rst             (rst),
        .exception_valid (exception_valid),
        .exception_cause (exception_cause),
        .exception_value (exception_value),
        .exception_pc    (exception_pc),
        .mret            (mret),
        .sret            (sret),
        .csr             (csr_bus),
        .priv            (priv),
        .trap_redirect   (trap_redirect),
        .trap_target     (trap_target)
    );

    typedef struct packed {
        logic        rst;
        logic        redirect;
        logic [31:0] target;
        logic        hit;
        logic [31:0] rdata;
        logic [1:0]  priv;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: privilege, architectural mstatus word and a CSR array indexed by address.
    logic [1:0]  m_priv;
    logic [31:0] m_ms;
    logic [31:0] m_csr [4096];

    logic [11:0] addr_pool [16] = '{12'h300, 12'h302, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h100, 12'h105, 12'h140, 12'h141, 12'h142,
                                    12'h143, 12'h102, 12'h344, 12'h000};
    logic [4:0]  cause_pool [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                     5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd15};

    function automatic logic [31:0] put(logic [31:0] w, logic [31:0] b, logic v);
        return v ? (w | b) : (w & ~b);
    endfunction

    function automatic bit m_hit(logic [11:0] a);
        case (a)
            12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: return 1'b1;
            12'h302, 12'h100, 12'h105, 12'h140, 12'h141, 12'h142, 12'h143: return SMODE;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] a);
        if (!m_hit(a)) return 32'h0;
        if (a == 12'h300) return m_ms;
        if (a == 12'h100) return m_ms & S_VIEW;
        return m_csr[a];
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] d);
        logic [1:0]  mpp;
        logic [31:0] keep;
        if (!m_hit(a)) return;
        case (a)
            12'h300: begin
                mpp = d[12:11];
                if (mpp == 2'b10 || (!SMODE && mpp == 2'b01)) mpp = m_ms[12:11];
                keep = B_MIE | B_MPIE | (SMODE ? S_VIEW : 32'h0);
                m_ms = d & keep;
                m_ms[12:11] = mpp;
            end
            12'h100: m_ms = (m_ms & ~S_VIEW) | (d & S_VIEW);
            12'h305, 12'h105, 12'h341, 12'h141: m_csr[a] = d & 32'hFFFF_FFFC;
            12'h302: m_csr[a] = d & 32'hFFFF_F7FF;
            default: m_csr[a] = d;
        endcase
    endtask

    task automatic m_reset();
        m_priv = 2'b11;
        m_ms   = '0;
        foreach (addr_pool[i]) m_csr[addr_pool[i]] = '0;
        m_csr[12'h305] = MTVEC_RST & 32'hFFFF_FFFC;
    endtask

    // Drive one cycle of stimulus, push the predicted outputs, then advance the model past the edge.
    task automatic txn(input bit r, input bit ev, input logic [4:0] cause,
                       input logic [31:0] pc, input logic [31:0] val,
                       input bit mr, input bit sr, input bit we,
                       input logic [11:0] addr, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] deleg;
        logic [1:0]  np;
        bit          to_s;
        @(posedge clk);
        #1;
        rst                = r;
        exception_valid    = ev;
        exception_cause    = exception_e'(cause);
        exception_pc       = pc;
        exception_value    = val;
        mret               = mr;
        sret               = sr;
        csr_bus.csr_we     = we;
        csr_bus.csr_addr   = addr;
        csr_bus.csr_wdata  = wd;
        e = '0;
        e.rst = r;
        if (r) begin
            sb_q.push_back(e);
            m_reset();
        end else begin
            e.redirect = ev || mr || (SMODE && sr);
            e.hit      = m_hit(addr);
            e.rdata    = m_read(addr);
            e.priv     = m_priv;
            if (ev) begin
                deleg = m_csr[12'h302];
                to_s  = SMODE && (m_priv != 2'b11) && deleg[cause];
                if (to_s) begin
                    e.target = m_csr[12'h105] & 32'hFFFF_FFFC;
                    m_csr[12'h141] = pc & 32'hFFFF_FFFC;
                    m_csr[12'h142] = {27'b0, cause};
                    m_csr[12'h143] = val;
                    m_ms = put(m_ms, B_SPIE, |(m_ms & B_SIE));
                    m_ms = put(m_ms, B_SIE, 1'b0);
                    m_ms = put(m_ms, B_SPP, m_priv == 2'b01);
                    m_priv = 2'b01;
                end else begin
                    e.target = m_csr[12'h305] & 32'hFFFF_FFFC;
                    m_csr[12'h341] = pc & 32'hFFFF_FFFC;
                    m_csr[12'h342] = {27'b0, cause};
                    m_csr[12'h343] = val;
                    m_ms = put(m_ms, B_MPIE, |(m_ms & B_MIE));
                    m_ms = put(m_ms, B_MIE, 1'b0);
                    m_ms[12:11] = m_priv;
                    m_priv = 2'b11;
                end
            end else if (mr) begin
                e.target = m_csr[12'h341];
                np = m_ms[12:11];
                m_ms = put(m_ms, B_MIE, |(m_ms & B_MPIE));
                m_ms = put(m_ms, B_MPIE, 1'b1);
                m_ms[12:11] = 2'b00;
                m_priv = np;
            end else if (SMODE && sr) begin
                e.target = m_csr[12'h141];
                m_priv = (|(m_ms & B_SPP)) ? 2'b01 : 2'b00;
                m_ms = put(m_ms, B_SIE, |(m_ms & B_SPIE));
                m_ms = put(m_ms, B_SPIE, 1'b1);
                m_ms = put(m_ms, B_SPP, 1'b0);
            end else if (we && !sr) begin
                m_write(addr, wd);
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic rd(input logic [11:0] a);
        txn(0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0, a, 32'h0);
    endtask
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        txn(0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 1, a, d);
    endtask
    task automatic exc(input logic [4:0] c, input logic [31:0] pc, input logic [31:0] v);
        txn(0, 1, c, pc, v, 0, 0, 0, CSR_MSTATUS, 32'h0);
    endtask
    task automatic do_mret();
        txn(0, 0, 5'd0, 32'h0, 32'h0, 1, 0, 0, CSR_MSTATUS, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle once outputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("trap_redirect", 32'(trap_redirect), 32'(e.redirect));
                if (!e.rst) begin
                    if (e.redirect) chk("trap_target", trap_target, e.target);
                    chk("csr_hit", 32'(csr_bus.csr_hit), 32'(e.hit));
                    chk("csr_rdata", csr_bus.csr_rdata, e.rdata);
                    chk("priv", 32'(priv), 32'(e.priv));
                end
            end
        end
    end

    initial begin
        csr_bus.csr_addr  = '0;
        csr_bus.csr_we    = 1'b0;
        csr_bus.csr_wdata = '0;

        txn(1, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0, CSR_MSTATUS, 32'h0);
        txn(1, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0, CSR_MSTATUS, 32'h0);
        rd(CSR_MTVEC); rd(CSR_MEPC); rd(CSR_MSTATUS); rd(CSR_MEDELEG);

        // Illegal instruction taken in M with a non-zero MODE field in mtvec.
        wr(CSR_MTVEC, 32'h8000_0041);
        wr(CSR_MSTATUS, 32'h0000_0008);
        exc(5'd2, 32'h8000_0104, 32'hFFFF_FFFF);
        rd(CSR_MEPC); rd(CSR_MCAUSE); rd(CSR_MTVAL); rd(CSR_MSTATUS);

        // mret to U, then a trap in the very next cycle.
        wr(CSR_MSTATUS, 32'h0000_0080);
        wr(CSR_MEPC, 32'h8000_0200);
        do_mret();
        exc(5'd3, 32'h8000_0300, 32'h0);
        rd(CSR_MSTATUS);

        // CSR write colliding with an exception is dropped.
        txn(0, 1, 5'd2, 32'h8000_0400, 32'h0, 0, 0, 1, CSR_MSCRATCH, 32'h0000_1234);
        rd(CSR_MSCRATCH);

        wr(CSR_MEPC, 32'h8000_0003);    rd(CSR_MEPC);
        wr(CSR_MSTATUS, 32'h0000_1000); rd(CSR_MSTATUS);
        wr(CSR_MEDELEG, 32'hFFFF_FFFF); rd(CSR_MEDELEG);

        // Delegated U ecall, then an undelegated S ecall.
        wr(CSR_MEDELEG, 32'h0000_0100);
        wr(CSR_STVEC, 32'h8000_2000);
        wr(CSR_MSTATUS, 32'h0000_0000);
        wr(CSR_MEPC, 32'h8000_1000);
        do_mret();
        exc(5'd8, 32'h8000_1000, 32'h0);
        rd(CSR_SSTATUS); rd(CSR_SCAUSE);
        exc(5'd9, 32'h8000_2004, 32'h0);
        rd(CSR_MSTATUS); rd(CSR_MCAUSE);

        // Reset asserted during an exception and a CSR write.
        wr(CSR_MEPC, 32'h8000_0500);
        txn(1, 1, 5'd2, 32'h8000_0600, 32'h1, 0, 0, 1, CSR_MSCRATCH, 32'h5555_5555);
        rd(CSR_MTVEC); rd(CSR_MEPC); rd(CSR_MSCRATCH);

        for (int i = 0; i < 500; i++) begin
            bit          r, ev, mr, sr, we;
            logic [11:0] a;
            logic [31:0] wd;
            r  = ($urandom_range(0, 99) < 2);
            ev = ($urandom_range(0, 99) < 15);
            mr = ($urandom_range(0, 99) < 10);
            sr = ($urandom_range(0, 99) < 10);
            we = ($urandom_range(0, 99) < 45);
            if (!SMODE && sr) we = 1'b0;
            a  = addr_pool[$urandom_range(0, 15)];
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) wd = {19'b0, 2'($urandom_range(0, 3)), wd[10:0]};
            txn(r, ev, cause_pool[$urandom_range(0, 13)], $urandom, $urandom, mr, sr, we, a, wd);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
